// File: rtl/ysyx_22051013_lsu_if.sv
// Bundle of every signal the load/store unit exchanges with its neighbours:
// the execute-stage op handshake, the load result toward write-back, and the
// single-outstanding data-memory bus.
//
// Modports:
//   slave  - the LSU itself (serves ops, drives the memory request side)
//   master - the surroundings: execute stage plus data memory
//
// Signals:
//   in_valid / in_ready        op handshake from EXU
//   ls_op[3:0]                 [3]=store, [2:0]=funct3 (b,h,w,d,bu,hu,wu,illegal)
//   ls_addr, ls_wdata          byte address and LSB-justified store data
//   ls_rd_data                 registered, extended load result
//   ls_done, ls_misalign       completion pulse and rejection flag
//   mem_req/we/addr/wdata/wmask request side of the data bus
//   mem_gnt, mem_rvalid, mem_rdata  response side of the data bus
//   dbg_state                  current LSU state (0 IDLE, 1 REQ, 2 RESP, 3 DONE)
interface ysyx_22051013_lsu_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        ls_op;
  logic [DATA_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rd_data;
  logic              ls_done;
  logic              ls_misalign;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  modport slave (
    input  in_valid, ls_op, ls_addr, ls_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, ls_rd_data, ls_done, ls_misalign,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, dbg_state
  );

  modport master (
    output in_valid, ls_op, ls_addr, ls_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, ls_rd_data, ls_done, ls_misalign,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, dbg_state
  );
endinterface

// File: rtl/ysyx_22051013_lsu.sv
// Load/store unit sitting just before write-back. Accepts one memory op per
// handshake, runs it over a single-outstanding 64-bit data bus, aligns and
// extends load data, builds store byte masks and shifted data, and rejects
// misaligned or illegal accesses without touching the bus.
//
// Ports:
//   clk  - core clock
//   rst  - synchronous, active-high reset
//   bus  - ysyx_22051013_lsu_if.slave (op handshake, result, memory bus, dbg_state)
//
// Handshakes:
//   in_valid/in_ready: an op transfers on a rising edge where both are high.
//   in_ready is a register that is high only in IDLE, so it never depends
//   combinationally on in_valid. mem_req/mem_gnt: the request and all its
//   attributes stay constant until an edge where mem_gnt is high; mem_req
//   drops right after. mem_rvalid is only looked at in RESP and mem_gnt only
//   in REQ; anything else on those lines is ignored.
module ysyx_22051013_lsu #(
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22051013_lsu_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic [3:0]        op_q;
  logic [2:0]        off_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic              misalign_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [7:0]        mem_wmask_q;

  // Decode of the op currently offered on the input side.
  logic [2:0]        f3_in;
  logic [2:0]        off_in;
  logic              misal_in;
  logic              illegal_in;
  logic              bad_in;
  logic [7:0]        mask_in;
  logic [DATA_W-1:0] wdata_in;

  assign f3_in  = bus.ls_op[2:0];
  assign off_in = bus.ls_addr[2:0];

  always_comb begin
    misal_in = 1'b0;
    mask_in  = 8'h00;
    // funct3[1:0] is the access size for both signed and unsigned loads.
    case (f3_in[1:0])
      2'b00: begin misal_in = 1'b0;           mask_in = 8'h01 << off_in; end
      2'b01: begin misal_in = off_in[0];      mask_in = 8'h03 << off_in; end
      2'b10: begin misal_in = |off_in[1:0];   mask_in = 8'h0F << off_in; end
      default: begin misal_in = |off_in;      mask_in = 8'hFF;           end
    endcase
  end

  // Stores have no unsigned variants; loads only lack encoding 111.
  assign illegal_in = bus.ls_op[3] ? f3_in[2] : (f3_in == 3'b111);
  assign bad_in     = misal_in | illegal_in;
  assign wdata_in   = bus.ls_wdata << {off_in, 3'b000};

  // Load data: bring the addressed bytes down to bit 0, then extend.
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] rd_ext;

  assign shifted = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    rd_ext = shifted;
    case (op_q[2:0])
      3'b000:  rd_ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  rd_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  rd_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  rd_ext = {56'd0, shifted[7:0]};
      3'b101:  rd_ext = {48'd0, shifted[15:0]};
      3'b110:  rd_ext = {32'd0, shifted[31:0]};
      default: rd_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      op_q        <= 4'd0;
      off_q       <= 3'd0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.ls_op;
            off_q      <= off_in;
            in_ready_q <= 1'b0;
            if (bad_in) begin
              // Rejected ops finish next cycle and never reach the bus.
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.ls_op[3];
              mem_addr_q  <= {bus.ls_addr[DATA_W-1:3], 3'b000};
              mem_wdata_q <= bus.ls_op[3] ? wdata_in : '0;
              mem_wmask_q <= bus.ls_op[3] ? mask_in : 8'h00;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            if (op_q[3]) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.mem_rvalid) begin
            rd_data_q <= rd_ext;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          done_q     <= 1'b0;
          misalign_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.ls_rd_data  = rd_data_q;
  assign bus.ls_done     = done_q;
  assign bus.ls_misalign = misalign_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wmask   = mem_wmask_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_ysyx_22051013_lsu.sv
// Directed bench for ysyx_22051013_lsu: loads, stores, rejected accesses,
// bus wait states with stray strobes, and reset in the middle of a load.
module tb_ysyx_22051013_lsu;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ysyx_22051013_lsu_if #(.DATA_W(W)) bus_if ();

  ysyx_22051013_lsu #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the loads.
  function automatic logic [W-1:0] mem_read(input logic [W-1:0] a);
    case (a)
      64'h0000_0000_8000_0008: return 64'h11223344_887766F5;
      64'h0000_0000_8000_0010: return 64'hCAFEBABE_0BADF00D;
      default:                 return 64'hDEADBEEF_DEADBEEF;
    endcase
  endfunction

  // Observations from the last run_op call.
  int           ob_lat;
  bit           ob_timeout;
  bit           ob_req_any;
  bit           ob_stable;
  bit           ob_busy_low;
  logic         ob_mis;
  logic [W-1:0] ob_rd;
  logic [W-1:0] ob_addr;
  logic [W-1:0] ob_wdata;
  logic [7:0]   ob_mask;
  logic         ob_we;

  // ---------------- driver ----------------
  // Called at a negedge. Offers the op, waits until in_ready says the next
  // edge accepts it, then plays the memory side cycle by cycle. Latency is
  // the number of edges after the accepting edge at which ls_done is seen.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                        input int gnt_wait, input int rv_wait, input bit hold_valid, input bit stray);
    int  gcnt;
    int  rcnt;
    int  k;
    bit  gnt_prev;
    bit  rv_done;
    bit  done;
    ob_lat = -1; ob_timeout = 0; ob_req_any = 0; ob_stable = 1; ob_busy_low = 1;
    ob_mis = 1'bx; ob_rd = 'x; ob_addr = 'x; ob_wdata = 'x; ob_mask = 'x; ob_we = 1'bx;
    bus_if.ls_op    = op;
    bus_if.ls_addr  = addr;
    bus_if.ls_wdata = wdata;
    bus_if.in_valid = 1'b1;
    k = 0;
    while (bus_if.in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus_if.in_ready !== 1'b1) begin
      ob_timeout = 1;
      bus_if.in_valid = 1'b0;
      return;
    end
    gcnt = 0; rcnt = 0; gnt_prev = 0; rv_done = 0; done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (!hold_valid) bus_if.in_valid = 1'b0;
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = '0;
      if (bus_if.in_ready !== 1'b0) ob_busy_low = 0;
      if (bus_if.mem_req === 1'b1) begin
        if (!ob_req_any) begin
          ob_req_any = 1;
          ob_addr  = bus_if.mem_addr;
          ob_wdata = bus_if.mem_wdata;
          ob_mask  = bus_if.mem_wmask;
          ob_we    = bus_if.mem_we;
        end else if ({bus_if.mem_addr, bus_if.mem_wdata, bus_if.mem_wmask, bus_if.mem_we}
                     !== {ob_addr, ob_wdata, ob_mask, ob_we}) begin
          ob_stable = 0;
        end
      end
      if (bus_if.ls_done === 1'b1) begin
        done = 1;
        ob_lat = c;
        ob_mis = bus_if.ls_misalign;
        ob_rd  = bus_if.ls_rd_data;
        bus_if.in_valid = 1'b0;
      end else if (bus_if.mem_req === 1'b1) begin
        if (gcnt == gnt_wait) begin
          bus_if.mem_gnt = 1'b1;
          gnt_prev = 1;
        end else begin
          gcnt++;
          if (stray) begin
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = 64'h5555_5555_5555_5555;
          end
        end
      end else if (gnt_prev && !rv_done && !op[3]) begin
        if (rcnt == rv_wait) begin
          bus_if.mem_rvalid = 1'b1;
          bus_if.mem_rdata  = mem_read(ob_addr);
          rv_done = 1;
        end else begin
          rcnt++;
          if (stray) bus_if.mem_gnt = 1'b1;
        end
      end
    end
    bus_if.in_valid   = 1'b0;
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    if (!done) ob_timeout = 1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] addr;
    logic [W-1:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp_addr;
    logic [W-1:0] exp_wdata;
    logic [7:0]   exp_mask;
  } st_vec_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] addr;
  } bad_vec_t;

  ld_vec_t ld_vecs[10] = '{
    '{4'b0000, 64'h8000_0008, 64'hFFFFFFFF_FFFFFFF5},  // lb
    '{4'b0100, 64'h8000_0008, 64'h00000000_000000F5},  // lbu
    '{4'b0010, 64'h8000_0008, 64'hFFFFFFFF_887766F5},  // lw
    '{4'b0110, 64'h8000_000C, 64'h00000000_11223344},  // lwu
    '{4'b0011, 64'h8000_0008, 64'h11223344_887766F5},  // ld
    '{4'b0001, 64'h8000_000A, 64'hFFFFFFFF_FFFF8877},  // lh
    '{4'b0101, 64'h8000_000E, 64'h00000000_00001122},  // lhu
    '{4'b0100, 64'h8000_0017, 64'h00000000_000000CA},  // lbu top byte
    '{4'b0000, 64'h8000_0011, 64'hFFFFFFFF_FFFFFFF0},  // lb
    '{4'b0010, 64'h8000_0014, 64'hFFFFFFFF_CAFEBABE}   // lw upper word
  };

  st_vec_t st_vecs[4] = '{
    '{4'b1001, 64'h8000_0012, 64'h00000000_0000ABCD, 64'h8000_0010, 64'h00000000_ABCD0000, 8'h0C},  // sh
    '{4'b1000, 64'h8000_0017, 64'h00000000_FFFFFF5A, 64'h8000_0010, 64'h5A000000_00000000, 8'h80},  // sb
    '{4'b1010, 64'h8000_001C, 64'h00000000_DEADBEEF, 64'h8000_0018, 64'hDEADBEEF_00000000, 8'hF0},  // sw
    '{4'b1011, 64'h8000_0020, 64'h01234567_89ABCDEF, 64'h8000_0020, 64'h01234567_89ABCDEF, 8'hFF}   // sd
  };

  bad_vec_t bad_vecs[7] = '{
    '{4'b0010, 64'h8000_0002},  // lw misaligned
    '{4'b0001, 64'h8000_0001},  // lh misaligned
    '{4'b0011, 64'h8000_0004},  // ld misaligned
    '{4'b0110, 64'h8000_0006},  // lwu misaligned
    '{4'b1100, 64'h8000_0008},  // store funct3 100
    '{4'b0111, 64'h8000_0008},  // load funct3 111
    '{4'b1010, 64'h8000_0003}   // sw misaligned
  };

  logic [W-1:0] last_rd;
  bit           done_seen;

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus_if.in_valid   = 1'b0;
    bus_if.ls_op      = 4'd0;
    bus_if.ls_addr    = '0;
    bus_if.ls_wdata   = '0;
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    bus_if.mem_rdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_val("rst_in_ready", W'(bus_if.in_ready), 64'd1);
    check_val("rst_state", W'(bus_if.dbg_state), 64'd0);
    check_val("rst_done_mis_req_we", W'({bus_if.ls_done, bus_if.ls_misalign, bus_if.mem_req, bus_if.mem_we}), 64'd0);
    check_val("rst_rd_data", bus_if.ls_rd_data, 64'd0);
    check_val("rst_mem_addr", bus_if.mem_addr, 64'd0);
    check_val("rst_mem_wdata", bus_if.mem_wdata, 64'd0);
    check_val("rst_mem_wmask", W'(bus_if.mem_wmask), 64'd0);

    // Loads with immediate grant and rvalid one cycle later.
    foreach (ld_vecs[i]) begin
      exp_q.push_back(ld_vecs[i].exp);
      run_op(ld_vecs[i].op, ld_vecs[i].addr, 64'd0, 0, 0, 0, 0);
      check_val($sformatf("ld%0d_timeout", i), W'(ob_timeout), 64'd0);
      check_val($sformatf("ld%0d_rd", i), ob_rd, exp_q.pop_front());
      check_val($sformatf("ld%0d_lat", i), W'(ob_lat), 64'd3);
      check_val($sformatf("ld%0d_mis", i), W'(ob_mis), 64'd0);
      check_val($sformatf("ld%0d_we", i), W'({ob_we, ob_mask}), 64'd0);
    end
    last_rd = 64'hFFFFFFFF_CAFEBABE;

    // Stores with immediate grant; load result must not move.
    foreach (st_vecs[i]) begin
      run_op(st_vecs[i].op, st_vecs[i].addr, st_vecs[i].wdata, 0, 0, 0, 0);
      check_val($sformatf("st%0d_timeout", i), W'(ob_timeout), 64'd0);
      check_val($sformatf("st%0d_addr", i), ob_addr, st_vecs[i].exp_addr);
      check_val($sformatf("st%0d_wdata", i), ob_wdata, st_vecs[i].exp_wdata);
      check_val($sformatf("st%0d_mask", i), W'(ob_mask), W'(st_vecs[i].exp_mask));
      check_val($sformatf("st%0d_we", i), W'(ob_we), 64'd1);
      check_val($sformatf("st%0d_lat", i), W'(ob_lat), 64'd2);
      check_val($sformatf("st%0d_rd_hold", i), ob_rd, last_rd);
    end

    // Rejected accesses: one-cycle completion, no bus traffic.
    foreach (bad_vecs[i]) begin
      run_op(bad_vecs[i].op, bad_vecs[i].addr, 64'h1234, 0, 0, 0, 0);
      check_val($sformatf("bad%0d_timeout", i), W'(ob_timeout), 64'd0);
      check_val($sformatf("bad%0d_lat", i), W'(ob_lat), 64'd1);
      check_val($sformatf("bad%0d_mis", i), W'(ob_mis), 64'd1);
      check_val($sformatf("bad%0d_req", i), W'(ob_req_any), 64'd0);
      check_val($sformatf("bad%0d_rd_hold", i), ob_rd, last_rd);
      @(negedge clk);
      check_val($sformatf("bad%0d_mis_clr", i), W'({bus_if.ls_misalign, bus_if.ls_done}), 64'd0);
    end

    // Grant held off 3 cycles, rvalid 2 cycles late, with in_valid held high
    // and stray rvalid/gnt pulses in the wrong states.
    exp_q.push_back(64'h11223344_887766F5);
    run_op(4'b0011, 64'h8000_0008, 64'd0, 3, 2, 1, 1);
    check_val("wait_timeout", W'(ob_timeout), 64'd0);
    check_val("wait_rd", ob_rd, exp_q.pop_front());
    check_val("wait_lat", W'(ob_lat), 64'd8);
    check_val("wait_req_stable", W'(ob_stable), 64'd1);
    check_val("wait_addr", ob_addr, 64'h8000_0008);
    check_val("wait_busy", W'(ob_busy_low), 64'd0 + 64'd1);
    check_val("wait_mis", W'(ob_mis), 64'd0);

    // Reset while waiting for read data, followed by a stale rvalid.
    @(negedge clk);
    bus_if.ls_op    = 4'b0011;
    bus_if.ls_addr  = 64'h8000_0008;
    bus_if.in_valid = 1'b1;
    check_val("rr_in_ready", W'(bus_if.in_ready), 64'd1);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check_val("rr_state_req", W'(bus_if.dbg_state), 64'd1);
    bus_if.mem_gnt = 1'b1;
    @(negedge clk);
    bus_if.mem_gnt = 1'b0;
    check_val("rr_state_resp", W'(bus_if.dbg_state), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = mem_read(64'h8000_0008);
    done_seen = 0;
    @(negedge clk);
    bus_if.mem_rvalid = 1'b0;
    check_val("rr_state_idle", W'(bus_if.dbg_state), 64'd0);
    check_val("rr_rd_data", bus_if.ls_rd_data, 64'd0);
    check_val("rr_in_ready_after", W'(bus_if.in_ready), 64'd1);
    check_val("rr_mem_req", W'(bus_if.mem_req), 64'd0);
    for (int c = 0; c < 3; c++) begin
      if (bus_if.ls_done !== 1'b0) done_seen = 1;
      @(negedge clk);
    end
    check_val("rr_no_done", W'(done_seen), 64'd0);

    // Normal operation resumes after the abandoned op.
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF5);
    run_op(4'b0000, 64'h8000_0008, 64'd0, 0, 0, 0, 0);
    check_val("post_timeout", W'(ob_timeout), 64'd0);
    check_val("post_rd", ob_rd, exp_q.pop_front());
    check_val("post_lat", W'(ob_lat), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
